// File: rtl/multi_evt_counter.sv
// NUM_CH modulo event counters with per-channel modulus, direction, wrap/saturate, clear,
// registered terminal pulse and sticky flag; optional carry cascade. 1-cycle latency, no backpressure.
module multi_evt_counter #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 8,
  parameter int DEFAULT_MAX = 6,
  parameter int CASCADE     = 0
) (
  input  logic                                           clk_in,
  input  logic                                           rst_n_in,
  input  logic [NUM_CH-1:0]                              evt_in,
  input  logic [NUM_CH-1:0]                              dir_in,
  input  logic                                           sat_mode_in,
  input  logic [NUM_CH-1:0]                              clr_in,
  input  logic                                           max_wr_in,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] max_ch_in,
  input  logic [WIDTH-1:0]                               max_data_in,
  output logic [NUM_CH*WIDTH-1:0]                        count_out,
  output logic [NUM_CH-1:0]                              hit_max_out,
  output logic [NUM_CH-1:0]                              ovf_sticky_out
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [WIDTH-1:0]  cnt_q [NUM_CH];
  logic [WIDTH-1:0]  cnt_d [NUM_CH];
  logic [WIDTH-1:0]  max_q [NUM_CH];
  logic [WIDTH-1:0]  max_d [NUM_CH];
  logic [WIDTH-1:0]  top_val [NUM_CH];
  logic [NUM_CH-1:0] hit_q, hit_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] evt_eff;
  logic [NUM_CH-1:0] term;
  logic              carry;

  // Terminal detection; a cleared channel never terminates, which also kills its carry.
  always_comb begin
    carry   = 1'b0;
    evt_eff = '0;
    term    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      top_val[k] = max_q[k] - WIDTH'(1);
      evt_eff[k] = (k == 0 || CASCADE == 0) ? evt_in[k] : carry;
      if (dir_in[k]) begin
        term[k] = evt_eff[k] & (cnt_q[k] >= top_val[k]) & ~clr_in[k];
      end else begin
        term[k] = evt_eff[k] & (cnt_q[k] == '0) & ~clr_in[k];
      end
      carry = term[k];
    end
  end

  always_comb begin
    hit_d = '0;
    ovf_d = ovf_q;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      max_d[k] = max_q[k];
      if (clr_in[k]) begin
        cnt_d[k] = '0;
        ovf_d[k] = 1'b0;
      end else if (term[k]) begin
        // up+wrap and down+sat land on 0; the other two land on M-1
        if (dir_in[k] == sat_mode_in) begin
          cnt_d[k] = top_val[k];
        end else begin
          cnt_d[k] = '0;
        end
        hit_d[k] = 1'b1;
        ovf_d[k] = 1'b1;
      end else if (evt_eff[k]) begin
        cnt_d[k] = dir_in[k] ? (cnt_q[k] + WIDTH'(1)) : (cnt_q[k] - WIDTH'(1));
      end
      if (max_wr_in && (max_data_in != '0) && (max_ch_in == CHW'(k))) begin
        max_d[k] = max_data_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
        max_q[k] <= WIDTH'(DEFAULT_MAX);
      end
      hit_q <= '0;
      ovf_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
        max_q[k] <= max_d[k];
      end
      hit_q <= hit_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    count_out = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      count_out[k*WIDTH +: WIDTH] = cnt_q[k];
    end
  end

  assign hit_max_out    = hit_q;
  assign ovf_sticky_out = ovf_q;

endmodule

// File: doc/multi_evt_counter.md
# multi_evt_counter

Parametrised, multi-channel successor to the single-channel SPI event counter. Provides NUM_CH independent event counters, each with a runtime-programmable modulus, per-channel count direction, wrap or saturate mode, synchronous clear, a registered terminal pulse and a sticky overflow flag. With cascading enabled, the channels chain into one multi-digit counter. Intended for SPI byte/word framing, line/pixel counting in the video path, and any place that needs several coupled modulo counters.

## Interface
- NUM_CH, 4: number of counter channels (≥1).
- WIDTH, 8: count and modulus width per channel (≥2).
- DEFAULT_MAX, 6: modulus loaded into every channel at reset (1..2^WIDTH-1).
- CASCADE, 0: 0 means channels are independent; 1 means channel k>0 counts the terminal events of channel k-1.

- clk_in  in  1  system clock, all logic on rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- evt_in  in  NUM_CH  per-channel event strobe, 1 cycle = 1 event. Bits 1..NUM_CH-1 are ignored when CASCADE=1.
- dir_in  in  NUM_CH  per-channel direction: 1 = up, 0 = down.
- sat_mode_in  in  1  global mode: 0 = wrap, 1 = saturate.
- clr_in  in  NUM_CH  per-channel synchronous clear.
- max_wr_in  in  1  modulus write strobe.
- max_ch_in  in  max(1,$clog2(NUM_CH))  channel selected for the modulus write.
- max_data_in  in  WIDTH  new modulus M.
- count_out  out  NUM_CH*WIDTH  flat count bus; channel k occupies bits [k*WIDTH +: WIDTH].
- hit_max_out  out  NUM_CH  one-cycle terminal pulse per channel.
- ovf_sticky_out  out  NUM_CH  sticky terminal flag per channel.

## Operation
- Each channel k holds a count C_k, a modulus register M_k and a sticky flag S_k. The legal count range is 0..M_k-1.
- Effective event for channel k:
  - E_0 = evt_in[0].
  - For k>0: E_k = evt_in[k] when CASCADE=0, or T_{k-1} when CASCADE=1.
- Terminal condition T_k (combinational):
  - Up: T_k = E_k & (C_k ≥ M_k-1). The ≥ comparison covers a modulus that was lowered below the current count.
  - Down: T_k = E_k & (C_k == 0).
- Next count, evaluated in priority order:
  1. clr_in[k]: C_k←0, S_k←0, hit←0.
  2. T_k with wrap mode: up gives C_k←0; down gives C_k←M_k-1. Then hit←1, S_k←1.
  3. T_k with saturate mode: up gives C_k←M_k-1; down gives C_k←0. Then hit←1, S_k←1.
  4. E_k without T_k: C_k←C_k±1.
  5. Otherwise hold; hit←0.
- A cleared channel produces no terminal. Under CASCADE=1 its carry into channel k+1 is therefore suppressed in that cycle. Channel k+1 still applies its own carry/clear rules.
- Modulus write: when max_wr_in=1 and max_data_in≠0, M[max_ch_in]←max_data_in.
  - A write with data 0 is ignored.
  - A write with max_ch_in ≥ NUM_CH is ignored.
  - A write does not alter C or S.
- M=1: every up event is terminal, so C stays 0 and hit pulses on each event.
- Arithmetic is unsigned, modulo 2^WIDTH internally. With legal M the result never actually overflows.

## Timing
- Reset (async assert, sync-safe deassert by the driver): C_k=0, M_k=DEFAULT_MAX, S_k=0, count_out=0, hit_max_out=0, ovf_sticky_out=0. Reset mid-count discards all state immediately.
- All outputs are registered. The count update and hit pulse appear one cycle after the sampled event.
- The hit pulse is coincident with the wrapped or saturated count value.
- A modulus write is visible from the next cycle. An event in the same cycle as a write uses the old M.
- Cascade ripple is combinational within one cycle, so all channels update on the same edge. The critical path is NUM_CH comparators deep.
- Back-to-back events every cycle are supported. There are no stalls and no handshake.

## Test plan
- Reset, then NUM_CH=4 and DEFAULT_MAX=6, evt_in[0] high for 7 cycles, up, wrap mode. Required: ch0 counts 1,2,3,4,5,0,1, with hit_max_out[0] high only on the 0, and S_0=1 afterwards.
- Down count on ch1 from 0, M=6, 2 events, wrap mode. Required: counts 5 then 4, with hit on the 5. Repeat in saturate mode: count stays 0 and hit pulses on each event.
- CASCADE=1, M=10 on all channels, 1000 events on ch0. Required: count_out digits 0,0,0,1 (ch3..ch0 = 1,0,0,0), with a single hit_max_out[2] pulse on the 1000th event.
- Count ch2 up to 5 with M=6, then write M=3. On the next event the count wraps to 0 with a hit. Writes of 0 and writes with max_ch_in out of range leave M unchanged.
- clr_in[0] in the same cycle as a terminal event on ch0 with CASCADE=1. Required: C_0=0, no hit, S_0 cleared, and ch1 does not increment.
- Assert rst_n_in low mid-cascade between clock edges. Required: all outputs go to 0 immediately, and M returns to DEFAULT_MAX.
